// File: rtl/mips_pc_pkg.sv
// rtl/mips_pc_pkg.sv - shared constants and FSM state type for the IF-stage PC unit
package mips_pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - control-transfer target arithmetic and next-PC priority mux
module pc_next_sel
  import mips_pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        run,
  input  logic        stall,
  input  logic [31:0] id_pc_plus4,
  input  logic        br_beq,
  input  logic        br_bne,
  input  logic        zero,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        taken,
  output logic        redirect,
  output logic        jr_misaligned
);

  logic [31:0] br_dest;
  logic [31:0] j_dest;
  logic [31:0] jr_dest;

  assign pc_plus4 = pc + INSTR_BYTES;

  // Wrap past either end of the address space is intentionally silent.
  assign br_dest = id_pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign j_dest  = {id_pc_plus4[31:28], jump_index, 2'b00};
  assign jr_dest = {jr_target[31:2], 2'b00};

  assign taken         = (br_beq & zero) | (br_bne & ~zero);
  assign jr_misaligned = jr & (jr_target[1:0] != 2'b00);

  // ID holds garbage during the boot bubble, so transfers only count in RUN.
  assign redirect = run & (jr | jump | taken);

  always_comb begin
    next_pc = pc_plus4;
    if (stall) begin
      next_pc = pc;
    end else if (run && jr) begin
      next_pc = jr_dest;
    end else if (run && jump) begin
      next_pc = j_dest;
    end else if (run && taken) begin
      next_pc = br_dest;
    end
  end

endmodule

// File: rtl/if_pc_redirect.sv
// rtl/if_pc_redirect.sv - IF-stage PC register, boot FSM and IF/ID flush generation
// Optional branch statistics counters are built when IF_PC_BRANCH_STATS_EN is defined.
module if_pc_redirect
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [ADDR_W-1:0] id_pc_plus4,
  input  logic              br_beq,
  input  logic              br_bne,
  input  logic              zero,
  input  logic [15:0]       br_offset,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_valid,
  output logic              if_id_flush,
  output logic              jr_misaligned
`ifdef IF_PC_BRANCH_STATS_EN
  ,
  output logic [31:0]       br_count,
  output logic [31:0]       br_taken_count
`endif
);

  pc_state_e   state;
  pc_state_e   state_next;
  logic [31:0] next_pc;
  logic        taken;
  logic        redirect;
  logic        run;

  assign run = (state == RUN);

  pc_next_sel u_sel (
    .pc            (pc),
    .run           (run),
    .stall         (stall),
    .id_pc_plus4   (id_pc_plus4),
    .br_beq        (br_beq),
    .br_bne        (br_bne),
    .zero          (zero),
    .br_offset     (br_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .taken         (taken),
    .redirect      (redirect),
    .jr_misaligned (jr_misaligned)
  );

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= next_pc;
    end
  end

  assign fetch_valid = run;
  assign if_id_flush = redirect & ~stall;

`ifdef IF_PC_BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count       <= 32'd0;
      br_taken_count <= 32'd0;
    end else if ((br_beq | br_bne) && !stall && run) begin
      br_count <= br_count + 32'd1;
      if (taken) begin
        br_taken_count <= br_taken_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_pc_redirect.sv
// tb/tb_if_pc_redirect.sv - directed table-driven bench for if_pc_redirect
// Counter checks are compiled in when IF_PC_BRANCH_STATS_EN is defined.
module tb_if_pc_redirect;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] id_pc_plus4;
  logic        br_beq;
  logic        br_bne;
  logic        zero;
  logic [15:0] br_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        if_id_flush;
  logic        jr_misaligned;
`ifdef IF_PC_BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] br_taken_count;
`endif

  always #5 clk = ~clk;

  if_pc_redirect dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .id_pc_plus4   (id_pc_plus4),
    .br_beq        (br_beq),
    .br_bne        (br_bne),
    .zero          (zero),
    .br_offset     (br_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .if_id_flush   (if_id_flush),
    .jr_misaligned (jr_misaligned)
`ifdef IF_PC_BRANCH_STATS_EN
    ,
    .br_count      (br_count),
    .br_taken_count(br_taken_count)
`endif
  );

  localparam logic [1:0] K_SEQ = 2'd0;
  localparam logic [1:0] K_HOLD = 2'd1;
  localparam logic [1:0] K_ABS = 2'd2;

  typedef struct {
    logic        stall;
    logic        beq;
    logic        bne;
    logic        zero;
    logic [15:0] off;
    logic        jump;
    logic [25:0] jidx;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] idpc;
    logic [1:0]  kind;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic        exp_mis;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_pc;
  vec_t        vecs[13];

  // Branch classes are mutually exclusive; jump and jr may overlap to exercise priority.
  always @(posedge clk) begin
    if (!reset) begin
      assert ($countones({br_beq, br_bne, jump | jr}) <= 1)
      else $error("FAIL decode_onehot: beq=%0b bne=%0b jump=%0b jr=%0b", br_beq, br_bne, jump, jr);
    end
  end

  function automatic vec_t mk(input logic st, input logic bq, input logic bn, input logic z,
                              input logic [15:0] o, input logic j, input logic [25:0] ji,
                              input logic r, input logic [31:0] rt, input logic [31:0] ip,
                              input logic [1:0] k, input logic [31:0] ep, input logic ef,
                              input logic em);
    vec_t v;
    v.stall = st; v.beq = bq; v.bne = bn; v.zero = z; v.off = o; v.jump = j; v.jidx = ji;
    v.jr = r; v.jrt = rt; v.idpc = ip; v.kind = k; v.exp_pc = ep; v.exp_flush = ef; v.exp_mis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; br_beq = v.beq; br_bne = v.bne; zero = v.zero; br_offset = v.off;
    jump = v.jump; jump_index = v.jidx; jr = v.jr; jr_target = v.jrt; id_pc_plus4 = v.idpc;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0, K_SEQ, 32'h0, 0, 0));
  endtask

  // Entered just after a negedge; leaves at the following negedge.
  task automatic run_vec(input string name, input vec_t v);
    logic [31:0] exp;
    drive(v);
    #1;
    check({name, ".flush"}, {31'b0, if_id_flush}, {31'b0, v.exp_flush});
    check({name, ".jr_mis"}, {31'b0, jr_misaligned}, {31'b0, v.exp_mis});
    check({name, ".pc_plus4"}, pc_plus4, model_pc + 32'd4);
    case (v.kind)
      K_SEQ:   exp = model_pc + 32'd4;
      K_HOLD:  exp = model_pc;
      default: exp = v.exp_pc;
    endcase
    @(negedge clk);
    check({name, ".pc"}, pc, exp);
    check({name, ".fetch_valid"}, {31'b0, fetch_valid}, 32'd1);
    model_pc = exp;
  endtask

  initial begin
    //            st bq bn z  off       j  jidx          jr jrt            idpc           kind    exp_pc         fl mis
    vecs[0]  = mk(0, 1, 0, 1, 16'hFFFC, 0, 26'h0,        0, 32'h0,         32'h0000_3010, K_ABS,  32'h0000_3000, 1, 0);
    vecs[1]  = mk(0, 1, 0, 0, 16'hFFFC, 0, 26'h0,        0, 32'h0,         32'h0000_3010, K_SEQ,  32'h0,         0, 0);
    vecs[2]  = mk(0, 0, 1, 1, 16'h0004, 0, 26'h0,        0, 32'h0,         32'h0000_3008, K_SEQ,  32'h0,         0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 16'h0004, 0, 26'h0,        0, 32'h0,         32'h0000_3008, K_ABS,  32'h0000_3018, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 16'h0,    1, 26'h010_0040, 0, 32'h0,         32'h0000_3020, K_ABS,  32'h0040_0100, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 16'h0,    1, 26'h010_0040, 1, 32'h0040_0007, 32'h0000_3020, K_ABS,  32'h0040_0004, 1, 1);
    vecs[6]  = mk(0, 0, 0, 0, 16'h0,    0, 26'h0,        1, 32'h0000_3100, 32'h0,         K_ABS,  32'h0000_3100, 1, 0);
    vecs[7]  = mk(0, 1, 0, 1, 16'h0008, 0, 26'h0,        0, 32'h0,         32'hFFFF_FFF0, K_ABS,  32'h0000_0010, 1, 0);
    vecs[8]  = mk(0, 0, 1, 0, 16'hFFFE, 0, 26'h0,        0, 32'h0,         32'h0000_0004, K_ABS,  32'hFFFF_FFFC, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 16'h0,    0, 26'h0,        0, 32'h0,         32'h0,         K_SEQ,  32'h0,         0, 0);
    vecs[10] = mk(1, 0, 0, 0, 16'h0,    1, 26'h123,      0, 32'h0,         32'h0000_3000, K_HOLD, 32'h0,         0, 0);
    vecs[11] = mk(0, 0, 0, 0, 16'h0,    0, 26'h0,        0, 32'h0,         32'h0,         K_SEQ,  32'h0,         0, 0);
    vecs[12] = mk(0, 0, 0, 0, 16'h0,    1, 26'h3FF_FFFF, 0, 32'h0,         32'hA000_0000, K_ABS,  32'hAFFF_FFFC, 1, 0);

    // Reset held for three edges, then the boot bubble with a jump that must be ignored.
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.pc", pc, 32'h0000_3000);
    check("reset.fetch_valid", {31'b0, fetch_valid}, 32'd0);
`ifdef IF_PC_BRANCH_STATS_EN
    check("reset.br_count", br_count, 32'd0);
    check("reset.br_taken_count", br_taken_count, 32'd0);
`endif
    reset = 1'b0;
    jump = 1'b1; jump_index = 26'h000_0100;
    #1;
    check("boot.pc", pc, 32'h0000_3000);
    check("boot.fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("boot.flush", {31'b0, if_id_flush}, 32'd0);
    @(negedge clk);
    idle();
    check("boot_exit.pc", pc, 32'h0000_3004);
    check("boot_exit.fetch_valid", {31'b0, fetch_valid}, 32'd1);
    @(negedge clk);
    check("seq.pc", pc, 32'h0000_3008);
    model_pc = 32'h0000_3008;

    for (int i = 0; i < 13; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // bne resolving taken while stalled two cycles: hold, then redirect on release.
    run_vec("bne_stall0", mk(1, 0, 1, 0, 16'h0010, 0, 26'h0, 0, 32'h0, 32'h0000_3040, K_HOLD, 32'h0, 0, 0));
    run_vec("bne_stall1", mk(1, 0, 1, 0, 16'h0010, 0, 26'h0, 0, 32'h0, 32'h0000_3040, K_HOLD, 32'h0, 0, 0));
    run_vec("bne_release", mk(0, 0, 1, 0, 16'h0010, 0, 26'h0, 0, 32'h0, 32'h0000_3040, K_ABS, 32'h0000_3080, 1, 0));

    // Reset mid-operation beats a pending jump and stall.
    reset = 1'b1; stall = 1'b1; jump = 1'b1; jump_index = 26'h000_0400; id_pc_plus4 = 32'h0000_3000;
    @(negedge clk);
    check("midreset.pc", pc, 32'h0000_3000);
    check("midreset.fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("midreset.flush", {31'b0, if_id_flush}, 32'd0);
    reset = 1'b0;
    idle();
    @(negedge clk);
    check("midreset_exit.pc", pc, 32'h0000_3004);
    model_pc = 32'h0000_3004;

    // Five counted branches (three taken) plus one stalled branch that must not count.
    run_vec("cnt0", mk(0, 1, 0, 1, 16'h0000, 0, 26'h0, 0, 32'h0, 32'h0000_3000, K_ABS, 32'h0000_3000, 1, 0));
    run_vec("cnt1", mk(0, 1, 0, 0, 16'h0000, 0, 26'h0, 0, 32'h0, 32'h0000_3000, K_SEQ, 32'h0, 0, 0));
    run_vec("cnt2", mk(0, 0, 1, 0, 16'h0000, 0, 26'h0, 0, 32'h0, 32'h0000_3000, K_ABS, 32'h0000_3000, 1, 0));
    run_vec("cnt3", mk(0, 0, 1, 1, 16'h0000, 0, 26'h0, 0, 32'h0, 32'h0000_3000, K_SEQ, 32'h0, 0, 0));
    run_vec("cnt4", mk(0, 1, 0, 1, 16'h0000, 0, 26'h0, 0, 32'h0, 32'h0000_3000, K_ABS, 32'h0000_3000, 1, 0));
    run_vec("cnt5", mk(1, 0, 1, 0, 16'h0000, 0, 26'h0, 0, 32'h0, 32'h0000_3000, K_HOLD, 32'h0, 0, 0));
    idle();
`ifdef IF_PC_BRANCH_STATS_EN
    check("stats.br_count", br_count, 32'd5);
    check("stats.br_taken_count", br_taken_count, 32'd3);
`endif
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
